// File: rtl/aos_packet_app_router.sv
// Steers AOSPacket beats from one input hold register into per-app FWFT FIFOs; unknown app IDs are dropped.
// Optional per-app delivery and drop counters are built when AOS_ROUTER_STATS_EN is defined.
module aos_packet_app_router #(
    parameter int NUM_APPS  = 4,
    parameter int APP_W     = 2,
    parameter int DATA_W    = 512,
    parameter int SLOT_W    = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [APP_W-1:0]           in_app,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SLOT_W-1:0]          in_slot,
    output logic [NUM_APPS-1:0]        out_valid,
    input  logic [NUM_APPS-1:0]        out_ready,
    output logic [NUM_APPS*DATA_W-1:0] out_data,
    output logic [NUM_APPS*SLOT_W-1:0] out_slot,
    output logic                       err_drop,
    output logic [NUM_APPS*32-1:0]     stat_pkts,
    output logic [31:0]                stat_drops
);

    localparam int DEPTH   = 1 << LOG_DEPTH;
    localparam int ENTRY_W = DATA_W + SLOT_W;
    localparam logic [LOG_DEPTH:0]   CNT_ONE  = 1;
    localparam logic [LOG_DEPTH:0]   CNT_FULL = DEPTH;
    localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;

    // Reset asserts immediately but releases two clocks later, in step with clk.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync_q <= 2'b11;
        else     rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic              h_valid_q;
    logic [APP_W-1:0]  h_app_q;
    logic [DATA_W-1:0] h_data_q;
    logic [SLOT_W-1:0] h_slot_q;

    logic [NUM_APPS-1:0] fifo_full;
    logic h_known, h_full, drain, accept, drop;
    logic err_drop_q;

    always_comb begin
        h_known = 1'b0;
        h_full  = 1'b0;
        for (int i = 0; i < NUM_APPS; i++) begin
            if (h_app_q == APP_W'(i)) begin
                h_known = 1'b1;
                h_full  = fifo_full[i];
            end
        end
    end

    assign drain    = h_valid_q && (!h_known || !h_full);
    assign in_ready = !h_valid_q || drain;
    assign accept   = in_valid && in_ready;
    assign drop     = drain && !h_known;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            h_valid_q  <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            if (accept)     h_valid_q <= 1'b1;
            else if (drain) h_valid_q <= 1'b0;
            err_drop_q <= drop;
        end
    end
    assign err_drop = err_drop_q;

    // NOTE: payload storage is left unreset; valid bits and counters gate every use of it.
    always_ff @(posedge clk) begin
        if (accept) begin
            h_app_q  <= in_app;
            h_data_q <= in_data;
            h_slot_q <= in_slot;
        end
    end

    for (genvar g = 0; g < NUM_APPS; g++) begin : g_app
        logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
        logic [LOG_DEPTH:0]   count_q;
        logic [ENTRY_W-1:0]   mem_q [DEPTH];
        logic [ENTRY_W-1:0]   head;
        logic                 push, pop;

        assign push = drain && h_known && (h_app_q == APP_W'(g));
        assign pop  = out_valid[g] && out_ready[g];

        always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (push && !pop)      count_q <= count_q + CNT_ONE;
                else if (!push && pop) count_q <= count_q - CNT_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= {h_data_q, h_slot_q};
        end

        assign head         = mem_q[rd_ptr_q];
        assign out_valid[g] = (count_q != '0);
        assign fifo_full[g] = (count_q == CNT_FULL);
        // Zero the lane when empty so reset and idle outputs are clean.
        assign out_data[g*DATA_W +: DATA_W] = out_valid[g] ? head[ENTRY_W-1:SLOT_W] : '0;
        assign out_slot[g*SLOT_W +: SLOT_W] = out_valid[g] ? head[SLOT_W-1:0] : '0;

`ifdef AOS_ROUTER_STATS_EN
        logic [31:0] pkts_q;
        always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int)  pkts_q <= '0;
            else if (pop) pkts_q <= pkts_q + 32'd1;
        end
        assign stat_pkts[g*32 +: 32] = pkts_q;
`else
        assign stat_pkts[g*32 +: 32] = '0;
`endif
    end

`ifdef AOS_ROUTER_STATS_EN
    logic [31:0] drops_q;
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int)   drops_q <= '0;
        else if (drop) drops_q <= drops_q + 32'd1;
    end
    assign stat_drops = drops_q;
`else
    assign stat_drops = '0;
`endif

endmodule

// File: tb/tb_aos_packet_app_router.sv
// Directed bench for aos_packet_app_router: default 4-app instance plus a 3-app instance for drops.
module tb_aos_packet_app_router;

    localparam int NA = 4, AW = 2, DW = 512, SW = 8, LD = 2, DEPTH = 4, NB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             in_valid, in_ready;
    logic [AW-1:0]    in_app;
    logic [DW-1:0]    in_data;
    logic [SW-1:0]    in_slot;
    logic [NA-1:0]    out_valid, out_ready;
    logic [NA*DW-1:0] out_data;
    logic [NA*SW-1:0] out_slot;
    logic             err_drop;
    logic [NA*32-1:0] stat_pkts;
    logic [31:0]      stat_drops;

    logic             b_in_valid, b_in_ready;
    logic [AW-1:0]    b_in_app;
    logic [DW-1:0]    b_in_data;
    logic [SW-1:0]    b_in_slot;
    logic [NB-1:0]    b_out_valid, b_out_ready;
    logic [NB*DW-1:0] b_out_data;
    logic [NB*SW-1:0] b_out_slot;
    logic             b_err_drop;
    logic [NB*32-1:0] b_stat_pkts;
    logic [31:0]      b_stat_drops;

    int errors = 0;
    int checks = 0;

    aos_packet_app_router #(.NUM_APPS(NA), .APP_W(AW), .DATA_W(DW), .SLOT_W(SW), .LOG_DEPTH(LD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_app(in_app),
        .in_data(in_data), .in_slot(in_slot), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_slot(out_slot), .err_drop(err_drop),
        .stat_pkts(stat_pkts), .stat_drops(stat_drops)
    );

    aos_packet_app_router #(.NUM_APPS(NB), .APP_W(AW), .DATA_W(DW), .SLOT_W(SW), .LOG_DEPTH(LD)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_app(b_in_app),
        .in_data(b_in_data), .in_slot(b_in_slot), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_slot(b_out_slot), .err_drop(b_err_drop),
        .stat_pkts(b_stat_pkts), .stat_drops(b_stat_drops)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0 || out_slot !== '0) begin errors++; $display("FAIL reset_out_data: nonzero data/slot"); end
        checks++; if (err_drop !== 1'b0 || stat_drops !== 32'd0 || stat_pkts !== '0) begin errors++; $display("FAIL reset_err_stats: err_drop=%b stat_drops=%0d", err_drop, stat_drops); end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = {64{8'hA5}};
        out_ready = '1;
        in_valid = 1'b1; in_app = 2'd2; in_data = d; in_slot = 8'd7;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_early: out_valid=%b want 0000", out_valid); end
        tick();
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL single_valid: out_valid=%b want 0100", out_valid); end
        checks++; if (out_data[2*DW +: DW] !== d) begin errors++; $display("FAIL single_data: got %h want %h", out_data[2*DW +: DW], d); end
        checks++; if (out_slot[2*SW +: SW] !== 8'd7) begin errors++; $display("FAIL single_slot: got %0d want 7", out_slot[2*SW +: SW]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL single_pop: out_valid=%b want 0000", out_valid); end
`ifdef AOS_ROUTER_STATS_EN
        checks++; if (stat_pkts[2*32 +: 32] !== 32'd1) begin errors++; $display("FAIL single_stat: got %0d want 1", stat_pkts[2*32 +: 32]); end
`else
        checks++; if (stat_pkts[2*32 +: 32] !== 32'd0) begin errors++; $display("FAIL single_stat: got %0d want 0", stat_pkts[2*32 +: 32]); end
`endif
        out_ready = '0;
    endtask

    task automatic test_back_to_back();
        out_ready = '0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_app = AW'(k % 4); in_data = DW'(k + 16); in_slot = SW'(k);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d: got %b want 1", k, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (out_valid[a] !== 1'b1 || out_data[a*DW +: DW] !== DW'(a + 4*j + 16) || out_slot[a*SW +: SW] !== SW'(a + 4*j)) begin
                    errors++;
                    $display("FAIL b2b_order app=%0d j=%0d: valid=%b data=%0h slot=%0d want data=%0h slot=%0d",
                             a, j, out_valid[a], out_data[a*DW +: 32], out_slot[a*SW +: SW], a + 4*j + 16, a + 4*j);
                end
                out_ready[a] = 1'b1;
                tick();
                out_ready[a] = 1'b0;
            end
            checks++; if (out_valid[a] !== 1'b0) begin errors++; $display("FAIL b2b_empty app=%0d: still valid", a); end
        end
    endtask

    // Streams n packets to one app; consumer idles for hold cycles, then pops every cycle or every other one.
    task automatic run_stream(input int app, input int base, input int n, input int hold, input bit toggle, input string tag);
        int sent, got, m_cnt;
        bit m_h, acc, pop, rdy, push, exp_rdy;
        logic [NA-1:0] exp_v;
        sent = 0; got = 0; m_cnt = 0; m_h = 0;
        for (int c = 0; c < 300 && got < n; c++) begin
            rdy = (c >= hold) && (!toggle || c[0]);
            out_ready = '0;
            out_ready[app] = rdy;
            in_valid = (sent < n);
            in_app = AW'(app); in_data = DW'(base + sent); in_slot = SW'(base + sent);
            exp_rdy = !m_h || (m_cnt < DEPTH);
            exp_v = '0;
            if (m_cnt > 0) exp_v[app] = 1'b1;
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL %s_ready c=%0d: got %b want %b", tag, c, in_ready, exp_rdy); end
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL %s_valid c=%0d: got %b want %b", tag, c, out_valid, exp_v); end
            acc = in_valid && exp_rdy;
            pop = (m_cnt > 0) && rdy;
            if (pop) begin
                checks++;
                if (out_data[app*DW +: DW] !== DW'(base + got) || out_slot[app*SW +: SW] !== SW'(base + got)) begin
                    errors++;
                    $display("FAIL %s_data idx=%0d: got %0h/%0d want %0h", tag, got, out_data[app*DW +: 32], out_slot[app*SW +: SW], base + got);
                end
            end
            tick();
            push = m_h && (m_cnt < DEPTH);
            m_cnt = m_cnt + int'(push) - int'(pop);
            m_h = acc || (m_h && !push);
            sent += int'(acc);
            got += int'(pop);
        end
        in_valid = 1'b0;
        out_ready = '0;
        checks++; if (got != n) begin errors++; $display("FAIL %s_count: delivered %0d want %0d", tag, got, n); end
    endtask

    task automatic test_backpressure();
        run_stream(1, 200, 6, 10, 1'b0, "bp");
    endtask

    task automatic test_full_simultaneous();
        run_stream(3, 300, 8, 8, 1'b1, "full");
    endtask

    task automatic test_drop();
        b_out_ready = '1;
        b_in_valid = 1'b1; b_in_app = 2'd3; b_in_data = DW'(32'hDEAD); b_in_slot = 8'd9;
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready: got %b want 1", b_in_ready); end
        tick();
        b_in_valid = 1'b0;
        checks++; if (b_err_drop !== 1'b0) begin errors++; $display("FAIL drop_early: err_drop=%b want 0", b_err_drop); end
        tick();
        checks++; if (b_err_drop !== 1'b1 || b_out_valid !== 3'b000) begin errors++; $display("FAIL drop_pulse: err_drop=%b out_valid=%b want 1/000", b_err_drop, b_out_valid); end
        tick();
        checks++; if (b_err_drop !== 1'b0 || b_out_valid !== 3'b000) begin errors++; $display("FAIL drop_end: err_drop=%b out_valid=%b want 0/000", b_err_drop, b_out_valid); end
`ifdef AOS_ROUTER_STATS_EN
        checks++; if (b_stat_drops !== 32'd1) begin errors++; $display("FAIL drop_stat: got %0d want 1", b_stat_drops); end
`else
        checks++; if (b_stat_drops !== 32'd0) begin errors++; $display("FAIL drop_stat: got %0d want 0", b_stat_drops); end
`endif
    endtask

    task automatic test_reset_midflight();
        out_ready = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_app = 2'd0; in_data = DW'(k + 500); in_slot = SW'(k);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 4'b0001) begin errors++; $display("FAIL rstmid_queued: out_valid=%b want 0001", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rstmid_data: out_data nonzero"); end
        tick();
        rst = 1'b0;
        out_ready = '1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (out_valid !== '0) begin errors++; $display("FAIL rstmid_stale c=%0d: out_valid=%b want 0", c, out_valid); end
        end
        out_ready = '0;
    endtask

    initial begin
        in_valid = 1'b0; in_app = '0; in_data = '0; in_slot = '0; out_ready = '0;
        b_in_valid = 1'b0; b_in_app = '0; b_in_data = '0; b_in_slot = '0; b_out_ready = '0;
        #12;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_simultaneous();
        test_drop();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
